hs_sink_rx: RTL and testbench
=============================

Name: hs_sink_rx

Overview:
- Clocked receiver that terminates the asynchronous 4-phase req/ack bundled-data pipeline at its output end.
- Synchronises the incoming request, captures the data word and returns the acknowledge.
- Buffers captured words in a small FIFO and presents them to the clocked domain over valid/ready.
- Sits downstream of the last asynchronous stage; it is the consumer/responder side of the stage handshake.

Parameters:
- DATA_W, 3, width of the bundled data word.
- SYNC_STAGES, 2, flops in the req_in synchroniser (min 2).
- FIFO_DEPTH, 4, receive buffer entries (power of 2, min 2).

Ports:
- clk  input  1  single clock for all state.
- rst  input  1  reset: one clock; reset is asynchronous and active-low.
- req_in  input  1  async request from the last pipeline stage (4-phase, return-to-zero).
- data_in  input  DATA_W  bundled data, stable from req_in rise until ack_out rise is seen upstream.
- ack_out  output  1  acknowledge to the pipeline; registered.
- dout  output  DATA_W  head-of-FIFO word.
- dout_valid  output  1  FIFO not empty.
- dout_ready  input  1  consumer accepts dout when high with dout_valid.
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- rx_count  output  8  words accepted since reset; wraps 255->0.

Behaviour:
- Reset (rst=0, async) clears: ack_out=0, dout_valid=0, dout=0, level=0, rx_count=0, synchroniser=0, FSM=IDLE, FIFO pointers=0.
- Reset mid-handshake drops ack_out immediately. Upstream must also be reset; a req held high after release is treated as a new request.
- req_s is req_in delayed through SYNC_STAGES flops. data_in is sampled only when req_s=1, so it is stable under bundled-data timing.
- FSM states: IDLE and ACK_HI.
- IDLE: ack_out=0. If req_s=1 and FIFO not full at that edge: push data_in, rx_count+1, ack_out<=1, go to ACK_HI. If the FIFO is full: stay in IDLE and withhold ack; the pipeline stalls.
- ACK_HI: ack_out=1. If req_s=0: ack_out<=0, go to IDLE. Otherwise hold. No capture happens in ACK_HI.
- Latency: req_in rise to ack_out rise is SYNC_STAGES+1 clock edges when not full. req_in fall to ack_out fall is also SYNC_STAGES+1 edges.
- Exactly one push per 4-phase cycle. A req glitch shorter than one clock may be missed; that is legal because the upstream holds req until ack.
- FIFO is first-word fall-through: dout = mem[rd_ptr], and dout_valid = (level != 0).
- Pop occurs when dout_valid and dout_ready. Pop on an empty FIFO is ignored.
- Full is evaluated from the registered level. Push and pop in the same cycle are both performed: level unchanged, pointers both advance.
- When full with a pending request, the push waits until the edge after a pop makes level < FIFO_DEPTH. There is no same-cycle pass-through.
- Pointers wrap modulo FIFO_DEPTH. level saturates naturally because it is never pushed beyond FIFO_DEPTH.
- dout is defined (0) when empty after reset. After being drained it holds the stale mem value, and the consumer must qualify it with dout_valid.

Decomposition:
- Shared package hs_pkg holds: the FSM state enum (IDLE, ACK_HI), the default DATA_W=3, and the default SYNC_STAGES=2 constant.
- One natural sub-module: hs_sync_fifo, a parameterised FWFT FIFO with push, pop, full, empty and level.
- The synchroniser and FSM stay inline in hs_sink_rx.

Test Plan:
- Single transfer: req_in=1 with data_in=3'b101, dout_ready=0 → ack_out rises 3 edges later. After req_in=0, ack_out falls 3 edges later. dout_valid=1, dout=5, level=1, rx_count=1.
- Stream of 4 words (1,2,3,4) with dout_ready=0 → level=4. A 5th request (7) gets no ack_out. Raise dout_ready for 1 cycle → dout=1 popped, then ack for 7 follows; order out is 2,3,4,7.
- Simultaneous push/pop: level=2 with dout_ready=1 held while a request is captured → level stays 2 on that edge, pointers wrap correctly past entry 3.
- Reset mid-handshake: assert rst=0 while ack_out=1 and level=3 → ack_out=0, level=0, dout_valid=0, rx_count=0 immediately, without waiting for clk.
- rx_count wrap: 256 full handshakes with dout_ready=1 → rx_count returns to 0, and no word is lost or duplicated (scoreboard compare).
- Slow req removal: hold req_in high for 20 clocks after ack → exactly one push. ack_out stays 1 until req_s falls.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared types and default sizing for the 4-phase bundled-data sink.
package hs_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACK_HI = 1'b1
  } hs_state_e;

  localparam int HS_DATA_W      = 3;
  localparam int HS_SYNC_STAGES = 2;
  localparam int HS_FIFO_DEPTH  = 4;

endpackage

// File: rtl/hs_sink_rx_if.sv
// Bundle of the async req/ack/data side and the clocked valid/ready side of the sink.
interface hs_sink_rx_if import hs_pkg::*; #(
  parameter int DATA_W     = HS_DATA_W,
  parameter int FIFO_DEPTH = HS_FIFO_DEPTH
) ();

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              req_in;
  logic [DATA_W-1:0] data_in;
  logic              ack_out;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic [LVL_W-1:0]  level;
  logic [7:0]        rx_count;

  modport master (
    output req_in, data_in, dout_ready,
    input  ack_out, dout, dout_valid, level, rx_count
  );

  modport slave (
    input  req_in, data_in, dout_ready,
    output ack_out, dout, dout_valid, level, rx_count
  );

endinterface

// File: rtl/hs_sync_fifo.sv
// First-word-fall-through FIFO: pop_dat shows the head with zero latency, push lands next edge.
// Push while full and pop while empty are ignored; fullness comes from the registered level.
module hs_sync_fifo #(
  parameter int W     = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];
  assign level   = level_q;

  // Storage is cleared on reset so the head reads 0 before the first push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/hs_sink_rx.sv
// Clocked terminator of a 4-phase req/ack pipeline: ack edges follow req edges by SYNC_STAGES+1 clocks.
// A full buffer withholds ack so the async pipeline stalls; words leave over valid/ready.
module hs_sink_rx import hs_pkg::*; #(
  parameter int DATA_W      = HS_DATA_W,
  parameter int SYNC_STAGES = HS_SYNC_STAGES,
  parameter int FIFO_DEPTH  = HS_FIFO_DEPTH
) (
  input logic         clk,
  input logic         rst,
  hs_sink_rx_if.slave bus
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  hs_state_e              state_q;
  hs_state_e              state_d;
  logic                   push;
  logic                   full;
  logic                   empty;
  logic                   ack_q;
  logic [7:0]             rx_q;

  assign req_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.req_in};
  end

  // Capture only on the IDLE->ACK_HI transition, giving one push per 4-phase cycle.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s && !full) begin
          push    = 1'b1;
          state_d = ACK_HI;
        end
      end
      ACK_HI: begin
        if (!req_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_d == ACK_HI);
      if (push) rx_q <= rx_q + 8'd1;
    end
  end

  hs_sync_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (bus.data_in),
    .pop      (bus.dout_ready),
    .pop_dat  (bus.dout),
    .full     (full),
    .empty    (empty),
    .level    (bus.level)
  );

  assign bus.ack_out    = ack_q;
  assign bus.dout_valid = !empty;
  assign bus.rx_count   = rx_q;

endmodule

// File: tb/tb_hs_sink_rx.sv
// Randomised and directed bench for hs_sink_rx against a queue-based word/occupancy model.
module tb_hs_sink_rx;

  logic clk;
  logic rst;

  hs_sink_rx_if #(.DATA_W(3), .FIFO_DEPTH(4)) bus ();

  hs_sink_rx #(.DATA_W(3), .SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         total;
  int         bad;
  logic [2:0] q[$];
  int         rx_model;
  int         pops;
  bit         sb_on;
  bit         rand_mode;
  logic       ready_cmd;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Consumer side: drives dout_ready mid-cycle and scores every pop against the model.
  initial begin
    bus.dout_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.dout_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_cmd;
      if (sb_on) begin
        chk("level", 32'(bus.level), 32'(q.size()));
        if (bus.dout_valid && bus.dout_ready) begin
          if (q.size() == 0) chk("underflow", 1, 0);
          else begin
            chk("dout", 32'(bus.dout), 32'(q[0]));
            void'(q.pop_front());
            pops++;
          end
        end
      end
    end
  end

  task automatic wait_ack(input logic lvl, input int bound, output int n);
    n = 0;
    while (bus.ack_out !== lvl && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.ack_out !== lvl) chk("ack_timeout", 32'(bus.ack_out), 32'(lvl));
  endtask

  task automatic do_hs(input logic [2:0] d, input int bound, output int rise_n, output int fall_n);
    bus.req_in  = 1'b1;
    bus.data_in = d;
    wait_ack(1'b1, bound, rise_n);
    if (bus.ack_out === 1'b1) begin
      q.push_back(d);
      rx_model++;
    end
    bus.req_in = 1'b0;
    wait_ack(1'b0, bound, fall_n);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int r, f;
    total = 0; bad = 0; rx_model = 0; pops = 0;
    sb_on = 0; rand_mode = 0; ready_cmd = 1'b0;
    bus.req_in = 1'b0; bus.data_in = '0;
    rst = 1'b0;
    #12;
    chk("rst_ack", 32'(bus.ack_out), 0);
    chk("rst_valid", 32'(bus.dout_valid), 0);
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_rx", 32'(bus.rx_count), 0);
    chk("rst_dout", 32'(bus.dout), 0);
    #1 rst = 1'b1;
    tick(1);
    sb_on = 1;

    // single transfer with latency measurement
    do_hs(3'b101, 20, r, f);
    chk("rise_lat", 32'(r), 3);
    chk("fall_lat", 32'(f), 3);
    chk("single_valid", 32'(bus.dout_valid), 1);
    chk("single_dout", 32'(bus.dout), 5);
    chk("single_level", 32'(bus.level), 1);
    chk("single_rx", 32'(bus.rx_count), 1);
    ready_cmd = 1'b1; tick(1); ready_cmd = 1'b0; tick(1);

    // fill, then stall on a full buffer
    for (int i = 1; i <= 4; i++) do_hs(3'(i), 20, r, f);
    chk("full_level", 32'(bus.level), 4);
    bus.req_in = 1'b1; bus.data_in = 3'd7;
    tick(10);
    chk("full_no_ack", 32'(bus.ack_out), 0);
    chk("full_rx", 32'(bus.rx_count), 5);
    ready_cmd = 1'b1; tick(1); ready_cmd = 1'b0;
    do_hs(3'd7, 20, r, f);
    chk("refill_level", 32'(bus.level), 4);
    chk("refill_rx", 32'(bus.rx_count), 6);
    ready_cmd = 1'b1; tick(2); ready_cmd = 1'b0; tick(1);
    chk("two_left", 32'(bus.level), 2);

    // push and pop on the same edge
    bus.req_in = 1'b1; bus.data_in = 3'd6;
    tick(2);
    ready_cmd = 1'b1;
    tick(1);
    ready_cmd = 1'b0;
    chk("pp_ack", 32'(bus.ack_out), 1);
    chk("pp_level", 32'(bus.level), 2);
    q.push_back(3'd6); rx_model++;
    bus.req_in = 1'b0;
    wait_ack(1'b0, 20, f);

    // req held long after ack: still one push
    bus.req_in = 1'b1; bus.data_in = 3'd2;
    wait_ack(1'b1, 20, r);
    q.push_back(3'd2); rx_model++;
    tick(20);
    chk("slow_ack", 32'(bus.ack_out), 1);
    chk("slow_rx", 32'(bus.rx_count), 32'(rx_model % 256));
    chk("slow_level", 32'(bus.level), 3);

    // asynchronous reset mid-handshake
    sb_on = 0;
    #2 rst = 1'b0;
    #1;
    chk("arst_ack", 32'(bus.ack_out), 0);
    chk("arst_level", 32'(bus.level), 0);
    chk("arst_valid", 32'(bus.dout_valid), 0);
    chk("arst_rx", 32'(bus.rx_count), 0);
    q.delete(); rx_model = 0; pops = 0;
    bus.req_in = 1'b0;
    #20 rst = 1'b1;
    tick(1);
    sb_on = 1;

    // 256 random handshakes with a random consumer: counter wrap and no loss
    rand_mode = 1;
    for (int i = 0; i < 256; i++) begin
      do_hs(3'($urandom_range(0, 7)), 300, r, f);
      tick($urandom_range(0, 3));
    end
    chk("wrap_rx", 32'(bus.rx_count), 0);
    chk("wrap_model", 32'(rx_model), 256);
    rand_mode = 0; ready_cmd = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) tick(1);
    tick(2);
    ready_cmd = 1'b0;
    chk("drain_level", 32'(bus.level), 0);
    chk("drain_pops", 32'(pops), 256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
